// File: rtl/apb_master.sv
// APB master bridging a one-cycle CPU request strobe onto up to four decoded APB slaves.
// Optional ACCESS-phase timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.

module apb_master #(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               transfer,
  input  logic [31:0]        addr,
  input  logic               write,
  input  logic [31:0]        wdata,
  output logic               ready,
  output logic [31:0]        rdata,
  output logic               err,
  output logic [31:0]        PADDR,
  output logic               PWRITE,
  output logic               PENABLE,
  output logic [31:0]        PWDATA,
  output logic [NUM_SLV-1:0] PSEL,
  input  logic [31:0]        PRDATA0,
  input  logic [31:0]        PRDATA1,
  input  logic [31:0]        PRDATA2,
  input  logic [31:0]        PRDATA3,
  input  logic               PREADY0,
  input  logic               PREADY1,
  input  logic               PREADY2,
  input  logic               PREADY3
);

  localparam logic [19:0] SlvBase = 20'h10000;

  if (NUM_SLV < 1 || NUM_SLV > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("apb_master: NUM_SLV must be 1..4 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    ERRDONE = 2'd3
  } state_e;

  state_e               state_q;
  logic [1:0]           idx_q;
  logic [NUM_SLV-1:0]   psel_q;
  logic                 penable_q;
  logic [31:0]          paddr_q;
  logic                 pwrite_q;
  logic [31:0]          pwdata_q;

  logic                 dec_hit;
  logic [1:0]           dec_idx;
  logic [NUM_SLV-1:0]   dec_sel;
  logic                 pready_sel;
  logic [31:0]          prdata_sel;
  logic                 done_c;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CntW-1:0] cnt_q;
`endif

  // Address decode: slave n owns the 4 KiB page at SlvBase + n.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = 2'd0;
    dec_sel = '0;
    for (int n = 0; n < int'(NUM_SLV); n++) begin
      if (addr[31:12] == SlvBase + 20'(n)) begin
        dec_hit    = 1'b1;
        dec_idx    = 2'(n);
        dec_sel[n] = 1'b1;
      end
    end
  end

  // Only the latched slave's response is observed.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    case (idx_q)
      2'd0: begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
      2'd1: begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
      2'd2: begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
      default: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
    endcase
  end

  // CPU-side completion follows PREADY in the same cycle, so it is combinational.
  always_comb begin
    done_c = (state_q == ACCESS) && pready_sel;
    ready  = done_c || (state_q == ERRDONE);
    err    = (state_q == ERRDONE);
    rdata  = (done_c && !pwrite_q) ? prdata_sel : 32'd0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            paddr_q  <= addr;
            pwrite_q <= write;
            pwdata_q <= wdata;
            idx_q    <= dec_idx;
            if (dec_hit) begin
              psel_q  <= dec_sel;
              state_q <= SETUP;
            end else begin
              state_q <= ERRDONE;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: begin
          if (pready_sel) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // cnt_q holds the number of earlier stalled ACCESS cycles.
          else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= ERRDONE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        ERRDONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: every transaction is predicted cycle by cycle from
// its address, direction and the slave's wait count, and compared against the DUT.

module tb_apb_master;

  localparam int NS = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif
  localparam int unsigned DUT_TMO = (TMO == 0) ? 255 : TMO;

  logic          clk = 1'b0;
  logic          preset;
  logic          transfer;
  logic [31:0]   addr;
  logic          write;
  logic [31:0]   wdata;
  logic          ready;
  logic [31:0]   rdata;
  logic          err;
  logic [31:0]   PADDR;
  logic          PWRITE;
  logic          PENABLE;
  logic [31:0]   PWDATA;
  logic [NS-1:0] PSEL;
  logic [31:0]   prdata [4];
  logic          pready [4];

  int checks = 0;
  int errors = 0;
  bit          fix_en = 1'b0;
  logic [31:0] fix_val = 32'd0;

  apb_master #(.NUM_SLV(NS), .TIMEOUT(DUT_TMO)) dut (
    .PCLK(clk), .PRESET(preset), .transfer(transfer), .addr(addr), .write(write),
    .wdata(wdata), .ready(ready), .rdata(rdata), .err(err), .PADDR(PADDR),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA), .PSEL(PSEL),
    .PRDATA0(prdata[0]), .PRDATA1(prdata[1]), .PRDATA2(prdata[2]), .PRDATA3(prdata[3]),
    .PREADY0(pready[0]), .PREADY1(pready[1]), .PREADY2(pready[2]), .PREADY3(pready[3])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel < 0: no selected slave, everything random.
  task automatic drive_slaves(input int sel, input logic sel_rdy);
    for (int k = 0; k < 4; k++) begin
      prdata[k] = $urandom;
      pready[k] = (k == sel) ? sel_rdy : 1'($urandom_range(0, 1));
    end
    if (sel >= 0 && fix_en) prdata[sel] = fix_val;
  endtask

  task automatic noise_req();
    transfer = 1'($urandom_range(0, 1));
    addr     = $urandom;
    write    = 1'($urandom_range(0, 1));
    wdata    = $urandom;
  endtask

  task automatic check_cpu(input string tag, input logic r, input logic e, input logic [31:0] d);
    chk({tag, "_ready"}, ready, r);
    chk({tag, "_err"}, err, e);
    chk({tag, "_rdata"}, rdata, d);
  endtask

  task automatic check_bus(input string tag, input logic [NS-1:0] sel, input logic en,
                           input logic [31:0] a, input logic w, input logic [31:0] wd);
    chk({tag, "_psel"}, PSEL, sel);
    chk({tag, "_penable"}, PENABLE, en);
    chk({tag, "_paddr"}, PADDR, a);
    chk({tag, "_pwrite"}, PWRITE, w);
    chk({tag, "_pwdata"}, PWDATA, wd);
  endtask

  task automatic check_zero(input string tag);
    check_cpu(tag, 1'b0, 1'b0, 32'd0);
    check_bus(tag, '0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // One request; the selected slave stalls wait_n ACCESS cycles, then gap idle cycles follow.
  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input int wait_n, input int gap);
    logic [19:0]   hi;
    logic          mapped;
    int            n;
    logic [NS-1:0] oh;
    bit            tmo;
    int            acc;
    logic          rdy;
    hi     = a[31:12];
    mapped = (hi >= 20'h10000) && (hi < 20'h10000 + 20'(NS));
    n      = mapped ? int'(hi - 20'h10000) : -1;
    oh     = '0;
    if (mapped) oh[n] = 1'b1;

    transfer = 1'b1; addr = a; write = w; wdata = wd;
    drive_slaves(-1, 1'b0);
    @(negedge clk);
    check_cpu("req", 1'b0, 1'b0, 32'd0);
    chk("req_psel", PSEL, '0);
    step();

    if (!mapped) begin
      noise_req();
      drive_slaves(-1, 1'b0);
      @(negedge clk);
      check_cpu("unmapped", 1'b1, 1'b1, 32'd0);
      chk("unmapped_psel", PSEL, '0);
      chk("unmapped_penable", PENABLE, 1'b0);
      step();
    end else begin
      noise_req();
      drive_slaves(n, 1'($urandom_range(0, 1)));
      @(negedge clk);
      check_bus("setup", oh, 1'b0, a, w, wd);
      check_cpu("setup", 1'b0, 1'b0, 32'd0);
      step();

      tmo = (TMO != 0) && (wait_n >= TMO);
      acc = tmo ? TMO : wait_n + 1;
      for (int j = 1; j <= acc; j++) begin
        rdy = (j > wait_n);
        noise_req();
        drive_slaves(n, rdy);
        @(negedge clk);
        check_bus("access", oh, 1'b1, a, w, wd);
        check_cpu("access", rdy, 1'b0, (rdy && !w) ? prdata[n] : 32'd0);
        step();
      end

      if (tmo) begin
        noise_req();
        drive_slaves(n, 1'b1);
        @(negedge clk);
        check_cpu("timeout", 1'b1, 1'b1, 32'd0);
        chk("timeout_psel", PSEL, '0);
        chk("timeout_penable", PENABLE, 1'b0);
        step();
      end
    end

    transfer = 1'b0;
    for (int g = 0; g < gap; g++) begin
      drive_slaves(-1, 1'b0);
      @(negedge clk);
      check_cpu("gap", 1'b0, 1'b0, 32'd0);
      chk("gap_psel", PSEL, '0);
      chk("gap_penable", PENABLE, 1'b0);
      step();
    end
  endtask

  // Transfer pulsed mid-ACCESS, then reset mid-ACCESS with a coincident strobe.
  task automatic reset_mid();
    transfer = 1'b1; addr = 32'h1000_3010; write = 1'b0; wdata = 32'h1234_5678;
    drive_slaves(-1, 1'b0);
    step();
    transfer = 1'b0;
    drive_slaves(3, 1'b0);
    @(negedge clk);
    check_bus("rst_setup", 4'b1000, 1'b0, 32'h1000_3010, 1'b0, 32'h1234_5678);
    step();
    transfer = 1'b1; addr = 32'h1000_0000; write = 1'b1;
    drive_slaves(3, 1'b0);
    @(negedge clk);
    chk("rst_acc1_ready", ready, 1'b0);
    chk("rst_acc1_paddr", PADDR, 32'h1000_3010);
    step();
    preset = 1'b1;
    drive_slaves(3, 1'b0);
    @(negedge clk);
    chk("rst_acc2_ready", ready, 1'b0);
    chk("rst_acc2_penable", PENABLE, 1'b1);
    step();
    addr = 32'h1000_1000;
    drive_slaves(-1, 1'b0);
    @(negedge clk);
    check_zero("rst_hold");
    step();
    preset = 1'b0; transfer = 1'b0;
    drive_slaves(-1, 1'b0);
    @(negedge clk);
    check_zero("rst_drop");
    step();
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    preset = 1'b1; transfer = 1'b1; addr = 32'h1000_0000; write = 1'b1; wdata = 32'hFFFF;
    drive_slaves(-1, 1'b0);
    repeat (2) step();
    @(negedge clk);
    check_zero("reset");
    step();
    preset = 1'b0; transfer = 1'b0;
    @(negedge clk);
    check_zero("post_reset");
    step();

    run_xfer(32'h1000_0000, 1'b1, 32'h0000_00A5, 0, 1);
    fix_en = 1'b1; fix_val = 32'h0000_00C3;
    run_xfer(32'h1000_1004, 1'b0, $urandom, 3, 1);
    fix_en = 1'b0;
    run_xfer(32'h2000_0000, 1'b0, 32'd0, 0, 0);
    reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
    run_xfer(32'h1000_2000, 1'b0, 32'd0, TMO + 5, 1);
    run_xfer(32'h1000_2000, 1'b0, 32'd0, TMO - 1, 1);
`endif
    run_xfer(32'h1000_3000, 1'b1, $urandom, 0, 0);
    run_xfer(32'h1000_0000, 1'b1, $urandom, 1, 1);
    run_xfer(32'h1000_3FFF, 1'b0, 32'd0, 2, 0);
    run_xfer(32'h1000_4000, 1'b0, 32'd0, 0, 0);
    run_xfer(32'h0FFF_FFFF, 1'b1, $urandom, 0, 1);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = {20'h10000 + 20'($urandom_range(0, NS - 1)), 12'($urandom)};
      else if (r == 7) a = $urandom;
      else if (r == 8) a = {20'h10000 + 20'(NS), 12'($urandom)};
      else             a = {20'h0FFFF, 12'($urandom)};
      run_xfer(a, 1'($urandom_range(0, 1)), $urandom,
               $urandom_range(0, (TMO != 0) ? TMO + 2 : 5), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
